// File: rtl/joy_serial_mp_if.sv
// Pin and status bundle for the serial joystick reader: chain pins, scan enable and player words.
// master = reader block, slave = board/chain side and consumer of the button words.
interface joy_serial_mp_if #(
  parameter int NUM_PLAYERS = 2
);
  logic                      en;
  logic                      JOY_DATA;
  logic                      JOY_LOAD;
  logic                      JOY_CLK;
  logic [NUM_PLAYERS*16-1:0] joystick;
  logic                      frame_done;
  logic [7:0]                frame_cnt;

  modport master (
    input  en, JOY_DATA,
    output JOY_LOAD, JOY_CLK, joystick, frame_done, frame_cnt
  );

  modport slave (
    output en, JOY_DATA,
    input  JOY_LOAD, JOY_CLK, joystick, frame_done, frame_cnt
  );
endinterface

// File: rtl/joy_serial_mp.sv
// Serial joystick reader for chained 74HC165 shifters; frame = (2+2*TOTAL+GAP_TICKS)*CLK_DIV+1 clks, no backpressure.
// Define JOY_SERIAL_DEBOUNCE_EN to require two identical consecutive frames before joystick changes.
module joy_serial_mp #(
  parameter int NUM_PLAYERS     = 2,
  parameter int BITS_PER_PLAYER = 12,
  parameter int CLK_DIV         = 8,
  parameter int GAP_TICKS       = 16
) (
  input  logic            clk,
  input  logic            RESET_L,
  joy_serial_mp_if.master joy
);

  localparam int TOTAL = NUM_PLAYERS * BITS_PER_PLAYER;
  localparam int JW    = NUM_PLAYERS * 16;
  localparam int IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, GAP} state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               phase_q, phase_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [TOTAL-1:0]   buf_q, buf_d;
  logic [1:0]         sync_q, sync_d;
  logic               load_q, load_d;
  logic               jclk_q, jclk_d;
  logic [JW-1:0]      joystick_q, joystick_d;
  logic               done_q, done_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [JW-1:0]      joy_new;
  logic               tick;
`ifdef JOY_SERIAL_DEBOUNCE_EN
  logic [JW-1:0]      raw_q, raw_d;
`endif

  // Inverted sample buffer laid out as one 16-bit lane per player; unused lane bits stay 0.
  always_comb begin
    joy_new = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      for (int b = 0; b < BITS_PER_PLAYER; b++) begin
        joy_new[p*16+b] = ~buf_q[p*BITS_PER_PLAYER+b];
      end
    end
  end

  assign tick = (div_q == DIV_W'(CLK_DIV - 1));

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    idx_d      = idx_q;
    gap_d      = gap_q;
    buf_d      = buf_q;
    load_d     = load_q;
    jclk_d     = jclk_q;
    joystick_d = joystick_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    sync_d     = {sync_q[0], joy.JOY_DATA};
`ifdef JOY_SERIAL_DEBOUNCE_EN
    raw_d      = raw_q;
`endif
    // The divider freezes during LATCH so that extra clk lengthens the frame by exactly one cycle.
    if (state_q == LATCH) div_d = div_q;
    else if (tick)        div_d = '0;
    else                  div_d = div_q + 1'b1;

    case (state_q)
      IDLE: begin
        load_d = 1'b1;
        jclk_d = 1'b1;
        if (tick && joy.en) begin
          state_d = LOAD;
          phase_d = 1'b0;
          load_d  = 1'b0;
        end
      end
      LOAD: begin
        if (tick) begin
          if (!phase_q) begin
            phase_d = 1'b1;
            load_d  = 1'b1;
          end else begin
            state_d = SHIFT;
            phase_d = 1'b0;
            idx_d   = '0;
            jclk_d  = 1'b0;
          end
        end
      end
      SHIFT: begin
        if (tick) begin
          if (!phase_q) begin
            buf_d[idx_q] = sync_q[1];
            phase_d      = 1'b1;
            jclk_d       = 1'b1;
          end else if (idx_q == IDX_W'(TOTAL - 1)) begin
            state_d = LATCH;
          end else begin
            idx_d   = idx_q + 1'b1;
            phase_d = 1'b0;
            jclk_d  = 1'b0;
          end
        end
      end
      LATCH: begin
`ifdef JOY_SERIAL_DEBOUNCE_EN
        raw_d = joy_new;
        if (joy_new == raw_q) joystick_d = joy_new;
`else
        joystick_d = joy_new;
`endif
        done_d  = 1'b1;
        cnt_d   = cnt_q + 8'd1;
        gap_d   = '0;
        state_d = GAP;
      end
      GAP: begin
        if (tick) begin
          if (gap_q == GAP_W'(GAP_TICKS - 1)) begin
            if (joy.en) begin
              state_d = LOAD;
              phase_d = 1'b0;
              load_d  = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q    <= IDLE;
      div_q      <= '0;
      phase_q    <= 1'b0;
      idx_q      <= '0;
      gap_q      <= '0;
      buf_q      <= '0;
      sync_q     <= 2'b11;
      load_q     <= 1'b1;
      jclk_q     <= 1'b1;
      joystick_q <= '0;
      done_q     <= 1'b0;
      cnt_q      <= 8'd0;
`ifdef JOY_SERIAL_DEBOUNCE_EN
      raw_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      phase_q    <= phase_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      buf_q      <= buf_d;
      sync_q     <= sync_d;
      load_q     <= load_d;
      jclk_q     <= jclk_d;
      joystick_q <= joystick_d;
      done_q     <= done_d;
      cnt_q      <= cnt_d;
`ifdef JOY_SERIAL_DEBOUNCE_EN
      raw_q      <= raw_d;
`endif
    end
  end

  assign joy.JOY_LOAD   = load_q;
  assign joy.JOY_CLK    = jclk_q;
  assign joy.joystick   = joystick_q;
  assign joy.frame_done = done_q;
  assign joy.frame_cnt  = cnt_q;

endmodule

// File: tb/tb_joy_serial_mp.sv
// Bench for joy_serial_mp: behavioural 74HC165 chain plus a frame-level timing/content model.
// Works with or without JOY_SERIAL_DEBOUNCE_EN defined.
module tb_joy_serial_mp;
  localparam int NP    = 2;
  localparam int BPP   = 12;
  localparam int CD    = 4;
  localparam int GT    = 2;
  localparam int TOTAL = NP * BPP;
  localparam int JW    = NP * 16;
  localparam int LAT    = (2 + 2 * TOTAL) * CD + 1;
  localparam int PERIOD = (2 + 2 * TOTAL + GT) * CD + 1;
`ifdef JOY_SERIAL_DEBOUNCE_EN
  localparam bit DEB = 1'b1;
`else
  localparam bit DEB = 1'b0;
`endif

  logic clk;
  logic RESET_L;
  joy_serial_mp_if #(.NUM_PLAYERS(NP)) js();

  joy_serial_mp #(
    .NUM_PLAYERS(NP), .BITS_PER_PLAYER(BPP), .CLK_DIV(CD), .GAP_TICKS(GT)
  ) dut (
    .clk(clk), .RESET_L(RESET_L), .joy(js.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Spec mapping: serial bit k belongs to player k/BPP, bit k%BPP.
  function automatic logic [JW-1:0] to_word(input logic [TOTAL-1:0] pat);
    logic [JW-1:0] w;
    w = '0;
    for (int k = 0; k < TOTAL; k++) w[(k / BPP) * 16 + (k % BPP)] = pat[k];
    return w;
  endfunction

  // Model / chain state
  logic [TOTAL-1:0] pat_q[$];
  logic [TOTAL-1:0] pend_pat[$];
  int               pend_due[$];
  logic [TOTAL-1:0] cur_pat = '0;
  logic [TOTAL-1:0] sr = '1;
  logic [JW-1:0]    exp_joy = '0, m_raw = '0;
  logic [7:0]       exp_cnt = 8'd0;
  logic             exp_done;
  logic             prev_load = 1'b1, prev_jclk = 1'b1;
  int cyc = 0, rises_frame = 0, clk_edges = 0, load_falls = 0;
  int dut_done = 0, last_done_cyc = 0, done_gap = 0, last_load_cyc = -1;

  // Chain model plus per-cycle compare, all at the falling clock edge.
  initial begin
    logic [TOTAL-1:0] p;
    int               d;
    logic [JW-1:0]    w;
    js.JOY_DATA = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      exp_done = 1'b0;
      if (!RESET_L) begin
        pend_pat.delete();
        pend_due.delete();
        exp_joy = '0; m_raw = '0; exp_cnt = 8'd0;
        rises_frame = 0; last_load_cyc = -1;
        prev_load = 1'b1; prev_jclk = 1'b1;
        chk("rst_load", js.JOY_LOAD, 1'b1);
        chk("rst_jclk", js.JOY_CLK, 1'b1);
      end else begin
        if (!js.en) last_load_cyc = -1;
        if (js.JOY_CLK != prev_jclk) clk_edges++;
        if (prev_load && !js.JOY_LOAD) begin
          if (pat_q.size() > 0) cur_pat = pat_q.pop_front();
          sr = ~cur_pat;
          load_falls++;
          if (last_load_cyc >= 0) chk("frame_period", cyc - last_load_cyc, PERIOD);
          last_load_cyc = cyc;
          rises_frame = 0;
          pend_due.push_back(cyc + LAT);
          pend_pat.push_back(cur_pat);
        end
        if (!prev_jclk && js.JOY_CLK && js.JOY_LOAD) begin
          sr = sr >> 1;
          rises_frame++;
        end
        if (!js.JOY_LOAD) sr = ~cur_pat;
        js.JOY_DATA = sr[0];
        if (pend_due.size() > 0 && pend_due[0] == cyc) begin
          d = pend_due.pop_front();
          p = pend_pat.pop_front();
          w = to_word(p);
          exp_done = 1'b1;
          exp_cnt  = exp_cnt + 8'd1;
          if (!DEB || w == m_raw) exp_joy = w;
          m_raw = w;
          chk("rises_per_frame", rises_frame, TOTAL);
        end
        prev_load = js.JOY_LOAD;
        prev_jclk = js.JOY_CLK;
      end
      if (js.frame_done) begin
        dut_done++;
        done_gap = cyc - last_done_cyc;
        last_done_cyc = cyc;
      end
      chk("frame_done", js.frame_done, exp_done);
      chk("joystick", js.joystick, exp_joy);
      chk("frame_cnt", js.frame_cnt, exp_cnt);
    end
  end

  task automatic wait_done(input int n);
    int tgt, k;
    tgt = dut_done + n;
    k = 0;
    while (dut_done < tgt && k < n * PERIOD + 2 * PERIOD) begin
      @(negedge clk); #1; k++;
    end
    chk("wait_done_in_budget", dut_done >= tgt, 1'b1);
  endtask

  task automatic wait_rises(input int n);
    int k;
    k = 0;
    while (rises_frame != n && k < 2 * PERIOD) begin
      @(negedge clk); #1; k++;
    end
    chk("wait_rises_in_budget", rises_frame, n);
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk); #2; RESET_L = 1'b0;
    #1;
    chk("async_rst_joystick", js.joystick, '0);
    chk("async_rst_cnt", js.frame_cnt, 8'd0);
    chk("async_rst_done", js.frame_done, 1'b0);
    chk("async_rst_load", js.JOY_LOAD, 1'b1);
    chk("async_rst_jclk", js.JOY_CLK, 1'b1);
    repeat (hold) @(negedge clk);
    #2; RESET_L = 1'b1;
  endtask

  localparam logic [TOTAL-1:0] P_BASE = 24'h00A001;
  localparam logic [TOTAL-1:0] P_B3   = 24'h000008;

  initial begin
    int e0, lf0, d0, k;
    logic [TOTAL-1:0] r;
    RESET_L = 1'b0;
    js.en   = 1'b0;
    repeat (5) @(negedge clk);
    #2; RESET_L = 1'b1;

    // Idle after reset with scanning disabled.
    e0 = clk_edges;
    repeat (1000) @(negedge clk);
    #1;
    chk("idle_load", js.JOY_LOAD, 1'b1);
    chk("idle_jclk", js.JOY_CLK, 1'b1);
    chk("idle_joystick", js.joystick, '0);
    chk("idle_cnt", js.frame_cnt, 8'd0);
    chk("idle_no_jclk_edges", clk_edges - e0, 0);
    chk("idle_no_loads", load_falls, 0);

    // Fixed pattern, continuous scanning.
    repeat (3) pat_q.push_back(24'h5A3C96);
    js.en = 1'b1;
    wait_done(1);
    if (!DEB) chk("pattern_frame1", js.joystick, 32'h05A3_0C96);
    wait_done(1);
    chk("pattern_frame2", js.joystick, 32'h05A3_0C96);
    chk("done_interval_2", done_gap, 209);
    wait_done(1);
    chk("done_interval_3", done_gap, 209);
    chk("pattern_cnt", js.frame_cnt, 8'd3);

    // Drop en during bit 10: frame finishes, then idle.
    wait_rises(10);
    js.en = 1'b0;
    d0 = dut_done;
    lf0 = load_falls;
    repeat (300) @(negedge clk);
    #1;
    chk("en_drop_one_done", dut_done - d0, 1);
    chk("en_drop_no_new_load", load_falls - lf0, 0);
    chk("en_drop_idle_load", js.JOY_LOAD, 1'b1);
    chk("en_drop_idle_jclk", js.JOY_CLK, 1'b1);
    js.en = 1'b1;
    k = 0;
    while (js.JOY_LOAD && k < 4 * CD) begin
      @(posedge clk); #1; k++;
    end
    chk("en_restart_load_low", js.JOY_LOAD, 1'b0);
    chk("en_restart_within_div", k <= CD, 1'b1);

    // Reset in the middle of SHIFT.
    wait_rises(5);
    do_reset(3);
    wait_done(1);
    chk("post_rst_full_frame", last_done_cyc - last_load_cyc, LAT);
    chk("post_rst_cnt", js.frame_cnt, 8'd1);

    // Glitch and held press on player-0 bit 3.
    pat_q.push_back(P_BASE);
    pat_q.push_back(P_BASE);
    pat_q.push_back(P_BASE | P_B3);
    pat_q.push_back(P_BASE);
    pat_q.push_back(P_BASE | P_B3);
    pat_q.push_back(P_BASE | P_B3);
    wait_done(1);
    wait_done(1);
    chk("stable_base", js.joystick, 32'h000A_0001);
    wait_done(1);
    chk("glitch_frame", js.joystick, DEB ? 32'h000A_0001 : 32'h000A_0009);
    wait_done(1);
    chk("after_glitch", js.joystick, 32'h000A_0001);
    wait_done(1);
    chk("press_frame1", js.joystick, DEB ? 32'h000A_0001 : 32'h000A_0009);
    wait_done(1);
    chk("press_frame2_bit3", js.joystick[3], 1'b1);
    chk("press_frame2", js.joystick, 32'h000A_0009);

    // 260 frames of random buttons, each pattern held for two frames.
    do_reset(2);
    for (int i = 0; i < 130; i++) begin
      r = TOTAL'($urandom);
      pat_q.push_back(r);
      pat_q.push_back(r);
    end
    d0 = dut_done;
    wait_done(256);
    chk("wrap_to_zero", js.frame_cnt, 8'd0);
    wait_done(4);
    chk("wrap_then_4", js.frame_cnt, 8'd4);
    chk("done_count_260", dut_done - d0, 260);

    js.en = 1'b0;
    repeat (20) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/joy_serial_mp.md
Name: joy_serial_mp

Overview:
- Generalised serial joystick reader for 74HC165-style parallel-in/serial-out chains on the UserIO port.
- Successor to the fixed two-player, 12-bit DB15 reader, with configurable player count, bits per player, shift clock rate and inter-frame gap.
- Generates JOY_LOAD/JOY_CLK, samples JOY_DATA, and presents active-high per-player button words to the emu top.
- Adds an enable/idle mode, a frame-done strobe, a frame counter and an optional debounce.

Parameters:
NUM_PLAYERS, 2, number of chained controllers (1..4)
BITS_PER_PLAYER, 12, button bits per controller (1..16)
CLK_DIV, 8, clk cycles per tick; one tick is one JOY_CLK half-period (>=2)
GAP_TICKS, 16, idle ticks between frames (>=1)

Ports:
clk  in  1  system clock (40-50 MHz)
RESET_L  in  1  asynchronous active-low reset
en  in  1  scanning enable; sampled only at frame boundaries
JOY_DATA  in  1  serial data from chain, active-low buttons
JOY_LOAD  out  1  parallel-load strobe, active-low
JOY_CLK  out  1  shift clock
joystick  out  NUM_PLAYERS*16  player p occupies [p*16+15:p*16]; bits >= BITS_PER_PLAYER are 0; active-high
frame_done  out  1  one-clk pulse when joystick updates (or would update)
frame_cnt  out  8  wrapping count of completed frames

Behaviour:
- Reset (async assert, sync release):
  - JOY_LOAD=1, JOY_CLK=1, joystick=0, frame_done=0, frame_cnt=0.
  - Tick divider=0; state=IDLE.
- Tick: divider counts 0..CLK_DIV-1; tick asserts on the terminal count. All state changes except LATCH occur on ticks.
- TOTAL = NUM_PLAYERS*BITS_PER_PLAYER.
- States:
  - IDLE: JOY_LOAD=1, JOY_CLK=1. On a tick with en=1, go to LOAD.
  - LOAD: JOY_LOAD=0 for 1 tick, then JOY_LOAD=1 for 1 tick (setup). Bit index=0, then go to SHIFT.
  - SHIFT: each bit takes 2 ticks.
    - Phase 0: JOY_CLK=0; JOY_DATA is sampled on the tick that ends phase 0.
    - Phase 1: JOY_CLK=1 (rising edge advances the chain).
    - Sampled bit k maps to player k/BITS_PER_PLAYER, bit k%BITS_PER_PLAYER.
    - After bit TOTAL-1, phase 1, go to LATCH.
  - LATCH: 1 clk, not tick-gated.
    - joystick <= inverted sample buffer.
    - frame_done=1 for this clk.
    - frame_cnt += 1, wrapping 255->0.
    - Go to GAP.
  - GAP: JOY_LOAD=1, JOY_CLK=1 for GAP_TICKS ticks, then LOAD if en=1, else IDLE.
- Frame period, continuous en: (2 + 2*TOTAL + GAP_TICKS)*CLK_DIV + 1 clk, with divider alignment as specified.
- en deassert mid-frame: the current frame completes and latches; the block stops in IDLE after GAP.
- en reassert in IDLE: the next tick enters LOAD.
- Reset mid-frame: the partial buffer is discarded; outputs return to reset values immediately.
- joystick holds its last value while idle. It never shows partial frames.
- JOY_DATA is double-flopped before sampling. The 2-clk synchroniser latency is absorbed within the half-tick (requires CLK_DIV>=2).

Optional Feature:
- Macro: JOY_SERIAL_DEBOUNCE_EN.
- Defined:
  - A raw register holds the previous frame's inverted buffer.
  - In LATCH, joystick updates only if the new buffer equals raw; raw is always updated.
  - frame_done and frame_cnt still advance every frame.
  - A new press therefore appears after 2 consecutive identical frames.
- Undefined: joystick updates every frame; the raw register is not built.

Test Plan:
- Reset release with en=0, CLK_DIV=4: JOY_LOAD=1, JOY_CLK=1, joystick=0, frame_cnt=0 for 1000 clks; no JOY_CLK edges.
- NUM_PLAYERS=2, BITS_PER_PLAYER=12, CLK_DIV=4, GAP_TICKS=2, en=1, model drives pattern 24'h5A3C96 (LSB first, active-low inverted) -> joystick[11:0]=12'hC96, joystick[27:16]=12'h5A3, upper nibbles 0. frame_done pulses exactly every 209 clks; exactly 24 JOY_CLK rising edges per frame.
- Same configuration, deassert en during bit 10 -> frame completes, frame_done pulses once, block idles with JOY_LOAD=1, JOY_CLK=1; reassert en -> JOY_LOAD low within CLK_DIV clks.
- Assert RESET_L=0 mid-SHIFT -> all outputs return to reset values in the same cycle. After release, the first frame_done pulse comes from a full new frame.
- Run 260 frames -> frame_cnt wraps 255->0->4; frame_done count=260.
- With JOY_SERIAL_DEBOUNCE_EN: single-frame glitch on player-0 bit 3 -> joystick unchanged. Press held 2 frames -> joystick[3]=1 at the second frame_done.
